// File: rtl/xadac_pkg.sv
// Shared types and constants for the xadac execution units.
// Holds the accumulator/vector geometry, request tag and immediate types,
// and the activation-unit additions: output width, activation type, the
// per-request configuration struct and the widened rounding type.
package xadac_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned SumWidth = 32;
    localparam int unsigned VecWidth = 128;
    localparam int unsigned IdWidth  = 8;
    localparam int unsigned ImmWidth = 8;

    typedef logic signed [SumWidth-1:0] SumT;
    typedef logic        [ImmWidth-1:0] ImmT;
    typedef logic        [IdWidth-1:0]  IdT;

    localparam int unsigned OutWidth = 8;

    typedef logic signed [OutWidth-1:0] ActT;

    typedef struct packed {
        logic [4:0] shamt;
        logic       relu;
    } VactvCfgT;

    // One extra bit over SumT so that adding the rounding term to the
    // most-negative or most-positive accumulator cannot wrap.
    typedef logic signed [SumWidth:0] RndT;

endpackage

// File: rtl/xadac_ex_if.sv
// Execution request/response interface between the issue logic and an
// execution unit.
// Request : req_valid/req_ready handshake, req_id tag, req_vs1 vector
//           operand, req_rs1 scalar operand, req_imm immediate.
// Response: resp_valid/resp_ready handshake, resp_id tag, resp_vd vector
//           result, resp_rd scalar result.
// Modports: slv (execution unit side), mst (issue side).
interface xadac_ex_if;
    import xadac_pkg::*;

    logic                req_valid;
    logic                req_ready;
    IdT                  req_id;
    logic [VecWidth-1:0] req_vs1;
    logic [XLEN-1:0]     req_rs1;
    ImmT                 req_imm;

    logic                resp_valid;
    logic                resp_ready;
    IdT                  resp_id;
    logic [VecWidth-1:0] resp_vd;
    logic [XLEN-1:0]     resp_rd;

    modport slv (
        input  req_valid, req_id, req_vs1, req_rs1, req_imm, resp_ready,
        output req_ready, resp_valid, resp_id, resp_vd, resp_rd
    );

    modport mst (
        output req_valid, req_id, req_vs1, req_rs1, req_imm, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_vd, resp_rd
    );

endinterface

// File: rtl/xadac_vactv_lane.sv
// Per-lane combinational datapath of the activation unit.
// First half (feeds stage 1 register):
//   acc, shamt, active -> rnd : round-half-up arithmetic right shift,
//                               forced to 0 for inactive lanes.
// Second half (fed from stage 1 register, feeds stage 2 register):
//   rnd_q, relu, active_q -> act, sat : optional ReLU, clamp to OutWidth,
//                               sat set when the clamp altered an active lane.
module xadac_vactv_lane #(
    parameter int unsigned OutWidth = 8
) (
    input  xadac_pkg::SumT      acc,
    input  logic [4:0]          shamt,
    input  logic                active,
    output xadac_pkg::RndT      rnd,
    input  xadac_pkg::RndT      rnd_q,
    input  logic                relu,
    input  logic                active_q,
    output logic [OutWidth-1:0] act,
    output logic                sat
);
    import xadac_pkg::*;

    localparam int  ActMax = (1 << (OutWidth - 1)) - 1;
    localparam int  ActMin = -(1 << (OutWidth - 1));
    localparam RndT RndMax = RndT'(ActMax);
    localparam RndT RndMin = RndT'(ActMin);

    RndT ext;
    RndT bias;
    RndT sum;
    RndT shr;
    RndT v;

    always_comb begin
        ext  = {acc[SumWidth-1], acc};
        bias = '0;
        if (shamt != 5'd0) begin
            bias = RndT'(1) << (shamt - 5'd1);
        end
        sum = ext + bias;
        shr = sum >>> shamt;
        rnd = active ? shr : '0;
    end

    // ReLU zeroing happens before the clamp so it never counts as saturation.
    always_comb begin
        v   = (relu && rnd_q[SumWidth]) ? '0 : rnd_q;
        act = v[OutWidth-1:0];
        sat = 1'b0;
        if (v > RndMax) begin
            act = RndMax[OutWidth-1:0];
            sat = active_q;
        end else if (v < RndMin) begin
            act = RndMin[OutWidth-1:0];
            sat = active_q;
        end
    end

endmodule

// File: rtl/xadac_vactv_unit.sv
// Vector activation unit: converts NrLanes SumT accumulators into packed
// signed OutWidth-bit activations (shift with round-half-up, optional ReLU,
// saturation) through a two-stage elastic pipeline.
// Ports:
//   clk  - clock, all state on rising edge
//   rstn - asynchronous active-low reset
//   slv  - xadac_ex_if slave port; req_rs1[4:0] shift, req_rs1[5] ReLU,
//          req_imm active lane count; resp_rd returns the saturated lane count.
module xadac_vactv_unit #(
    parameter int unsigned NrLanes  = xadac_pkg::VecWidth / xadac_pkg::SumWidth,
    parameter int unsigned OutWidth = 8,
    parameter int unsigned MaxShift = 31
) (
    input  logic    clk,
    input  logic    rstn,
    xadac_ex_if.slv slv
);
    import xadac_pkg::*;

    logic v1;
    logic v2;
    logic ready_s1;
    logic ready_s2;
    logic accept;
    logic load2;

    assign ready_s2      = !v2 || slv.resp_ready;
    assign ready_s1      = !v1 || ready_s2;
    assign slv.req_ready = ready_s1;
    assign accept        = slv.req_valid && ready_s1;
    assign load2         = v1 && ready_s2;

    logic [4:0] sh_raw;
    VactvCfgT   cfg_in;
    ImmT        imm_eff;
    logic       unused_rs1;

    assign sh_raw        = slv.req_rs1[4:0];
    assign cfg_in.shamt  = (32'(sh_raw) > MaxShift) ? 5'(MaxShift) : sh_raw;
    assign cfg_in.relu   = slv.req_rs1[5];
    assign imm_eff       = (slv.req_imm > ImmT'(NrLanes)) ? ImmT'(NrLanes) : slv.req_imm;
    assign unused_rs1    = ^slv.req_rs1[XLEN-1:6];

    RndT                 rnd_d [NrLanes];
    RndT                 rnd_q [NrLanes];
    logic [OutWidth-1:0] act   [NrLanes];
    logic [NrLanes-1:0]  sat;
    IdT                  id1;
    logic                relu1;
    ImmT                 imm1;

    for (genvar i = 0; i < NrLanes; i++) begin : g_lane
        xadac_vactv_lane #(
            .OutWidth (OutWidth)
        ) u_lane (
            .acc      (slv.req_vs1[SumWidth*i +: SumWidth]),
            .shamt    (cfg_in.shamt),
            .active   (ImmT'(i) < imm_eff),
            .rnd      (rnd_d[i]),
            .rnd_q    (rnd_q[i]),
            .relu     (relu1),
            .active_q (ImmT'(i) < imm1),
            .act      (act[i]),
            .sat      (sat[i])
        );
    end

    logic [VecWidth-1:0] vd_d;
    logic [XLEN-1:0]     rd_d;

    always_comb begin
        vd_d = '0;
        for (int i = 0; i < NrLanes; i++) begin
            vd_d[OutWidth*i +: OutWidth] = act[i];
        end
    end

    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NrLanes; i++) begin
            rd_d = rd_d + XLEN'(sat[i]);
        end
    end

    IdT                  resp_id_q;
    logic [VecWidth-1:0] resp_vd_q;
    logic [XLEN-1:0]     resp_rd_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            id1       <= '0;
            relu1     <= 1'b0;
            imm1      <= '0;
            for (int i = 0; i < NrLanes; i++) begin
                rnd_q[i] <= '0;
            end
            resp_id_q <= '0;
            resp_vd_q <= '0;
            resp_rd_q <= '0;
        end else begin
            v1 <= accept || (v1 && !ready_s2);
            v2 <= load2 || (v2 && !slv.resp_ready);
            if (accept) begin
                id1   <= slv.req_id;
                relu1 <= cfg_in.relu;
                imm1  <= imm_eff;
                for (int i = 0; i < NrLanes; i++) begin
                    rnd_q[i] <= rnd_d[i];
                end
            end
            if (load2) begin
                resp_id_q <= id1;
                resp_vd_q <= vd_d;
                resp_rd_q <= rd_d;
            end
        end
    end

    assign slv.resp_valid = v2;
    assign slv.resp_id    = resp_id_q;
    assign slv.resp_vd    = resp_vd_q;
    assign slv.resp_rd    = resp_rd_q;

endmodule

// File: tb/tb_xadac_vactv_unit.sv
// Directed self-checking bench for xadac_vactv_unit.
module tb_xadac_vactv_unit;
    import xadac_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    xadac_ex_if ex_if ();

    xadac_vactv_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .slv  (ex_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [127:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    task automatic drive_req(input IdT id, input logic [127:0] vs1, input logic [31:0] rs1, input ImmT imm);
        ex_if.req_valid = 1'b1;
        ex_if.req_id    = id;
        ex_if.req_vs1   = vs1;
        ex_if.req_rs1   = rs1;
        ex_if.req_imm   = imm;
    endtask

    // Sends one op with resp_ready high and returns what retires.
    // lat is the number of cycles from the request cycle to resp_valid, -1 on timeout.
    task automatic run_single(input IdT id, input logic [127:0] vs1, input logic [31:0] rs1, input ImmT imm,
                              output IdT got_id, output logic [127:0] got_vd, output logic [31:0] got_rd,
                              output int lat);
        bit acc;
        bit found;
        int n;
        drive_req(id, vs1, rs1, imm);
        ex_if.resp_ready = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = ex_if.req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        ex_if.req_valid = 1'b0;
        lat    = -1;
        got_id = '0;
        got_vd = '0;
        got_rd = '0;
        found  = 1'b0;
        if (acc) begin
            for (int k = 1; k <= 10 && !found; k++) begin
                @(negedge clk);
                if (ex_if.resp_valid) begin
                    found  = 1'b1;
                    lat    = k;
                    got_id = ex_if.resp_id;
                    got_vd = ex_if.resp_vd;
                    got_rd = ex_if.resp_rd;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        ex_if.req_valid  = 1'b0;
        ex_if.req_id     = '0;
        ex_if.req_vs1    = '0;
        ex_if.req_rs1    = '0;
        ex_if.req_imm    = '0;
        ex_if.resp_ready = 1'b0;
        #1 rstn = 1'b0;
        #2;
        checks++;
        if (ex_if.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", ex_if.resp_valid); end
        checks++;
        if (ex_if.resp_id !== '0) begin errors++; $display("FAIL reset_resp_id got %h exp 0", ex_if.resp_id); end
        checks++;
        if (ex_if.resp_vd !== '0) begin errors++; $display("FAIL reset_resp_vd got %h exp 0", ex_if.resp_vd); end
        checks++;
        if (ex_if.resp_rd !== '0) begin errors++; $display("FAIL reset_resp_rd got %h exp 0", ex_if.resp_rd); end
        checks++;
        if (ex_if.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", ex_if.req_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        IdT gid; logic [127:0] gvd; logic [31:0] grd; int lat;
        run_single(8'h11, pack4(40, -40, 2047, -2056), 32'd4, 8'd4, gid, gvd, grd, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d exp 2", lat); end
        checks++;
        if (gid !== 8'h11) begin errors++; $display("FAIL single_id got %h exp 11", gid); end
        checks++;
        if (gvd !== {96'd0, 32'h807FFE03}) begin errors++; $display("FAIL single_vd got %h exp 807ffe03", gvd); end
        checks++;
        if (grd !== 32'd1) begin errors++; $display("FAIL single_rd got %0d exp 1", grd); end
    endtask

    task automatic test_relu();
        IdT gid; logic [127:0] gvd; logic [31:0] grd; int lat;
        run_single(8'h22, pack4(-5, 7, 300, -1000), 32'h20, 8'd4, gid, gvd, grd, lat);
        checks++;
        if (gvd !== {96'd0, 32'h007F0700}) begin errors++; $display("FAIL relu_vd got %h exp 007f0700", gvd); end
        checks++;
        if (grd !== 32'd1) begin errors++; $display("FAIL relu_rd got %0d exp 1", grd); end
        checks++;
        if (gid !== 8'h22) begin errors++; $display("FAIL relu_id got %h exp 22", gid); end
    endtask

    task automatic test_imm();
        IdT gid; logic [127:0] gvd; logic [31:0] grd; int lat;
        run_single(8'h31, pack4(1, 2, 3, 4), 32'd0, 8'd2, gid, gvd, grd, lat);
        checks++;
        if (gvd !== {96'd0, 32'h00000201}) begin errors++; $display("FAIL imm2_vd got %h exp 00000201", gvd); end
        checks++;
        if (grd !== 32'd0) begin errors++; $display("FAIL imm2_rd got %0d exp 0", grd); end
        run_single(8'h32, pack4(1, 2, 3, 4), 32'd0, 8'd0, gid, gvd, grd, lat);
        checks++;
        if (gvd !== 128'd0) begin errors++; $display("FAIL imm0_vd got %h exp 0", gvd); end
        checks++;
        if (grd !== 32'd0) begin errors++; $display("FAIL imm0_rd got %0d exp 0", grd); end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL imm0_latency got %0d exp 2", lat); end
        // upper rs1 bits set but shift 0, relu 0; imm beyond lane count
        run_single(8'h33, pack4(1, 2, 3, 4), 32'hFFFF_FFC0, 8'd9, gid, gvd, grd, lat);
        checks++;
        if (gvd !== {96'd0, 32'h04030201}) begin errors++; $display("FAIL imm9_vd got %h exp 04030201", gvd); end
        // saturating value in an inactive lane must not count
        run_single(8'h34, pack4(500, 2, 300, 999), 32'd0, 8'd3, gid, gvd, grd, lat);
        checks++;
        if (gvd !== {96'd0, 32'h007F027F}) begin errors++; $display("FAIL imm3_vd got %h exp 007f027f", gvd); end
        checks++;
        if (grd !== 32'd2) begin errors++; $display("FAIL imm3_rd got %0d exp 2", grd); end
    endtask

    task automatic test_extremes();
        IdT gid; logic [127:0] gvd; logic [31:0] grd; int lat;
        run_single(8'h41, pack4(32'sh8000_0000, 32'sh7FFF_FFFF, 0, 32'shC000_0000), 32'd31, 8'd4,
                   gid, gvd, grd, lat);
        checks++;
        if (gvd !== {96'd0, 32'h000001FF}) begin errors++; $display("FAIL sh31_vd got %h exp 000001ff", gvd); end
        checks++;
        if (grd !== 32'd0) begin errors++; $display("FAIL sh31_rd got %0d exp 0", grd); end
        run_single(8'h42, pack4(32'sh7FFF_FFFF, 32'sh8000_0000, 0, 0), 32'd1, 8'd4, gid, gvd, grd, lat);
        checks++;
        if (gvd !== {96'd0, 32'h0000807F}) begin errors++; $display("FAIL sh1_vd got %h exp 0000807f", gvd); end
        checks++;
        if (grd !== 32'd2) begin errors++; $display("FAIL sh1_rd got %0d exp 2", grd); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] in_vs  [5];
        logic [31:0]  exp_vd [5];
        int           exp_rd [5];
        int  sent;
        int  got;
        int  drop_at;
        bit  prev_stall;
        IdT           snap_id;
        logic [127:0] snap_vd;
        logic [31:0]  snap_rd;
        in_vs[0] = pack4(10, -10, 300, 5);        exp_vd[0] = 32'h037FFB05; exp_rd[0] = 1;
        in_vs[1] = pack4(1, -1, -3, 255);         exp_vd[1] = 32'h7FFF0001; exp_rd[1] = 1;
        in_vs[2] = pack4(-300, -257, -256, 254);  exp_vd[2] = 32'h7F808080; exp_rd[2] = 1;
        in_vs[3] = pack4(0, 2, 4, 6);             exp_vd[3] = 32'h03020100; exp_rd[3] = 0;
        in_vs[4] = pack4(1000, -1000, 1000, -1000); exp_vd[4] = 32'h807F807F; exp_rd[4] = 4;
        sent = 0; got = 0; drop_at = -1; prev_stall = 1'b0;
        snap_id = '0; snap_vd = '0; snap_rd = '0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            ex_if.resp_ready = (cyc >= 1 && cyc <= 3) ? 1'b0 : 1'b1;
            if (sent < 5) drive_req(IdT'(8'h50 + sent), in_vs[sent], 32'd1, 8'd4);
            else ex_if.req_valid = 1'b0;
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if ({ex_if.resp_valid, ex_if.resp_id, ex_if.resp_vd, ex_if.resp_rd} !==
                    {1'b1, snap_id, snap_vd, snap_rd}) begin
                    errors++;
                    $display("FAIL b2b_stall_stable got id %h vd %h rd %0d exp id %h vd %h rd %0d",
                             ex_if.resp_id, ex_if.resp_vd, ex_if.resp_rd, snap_id, snap_vd, snap_rd);
                end
            end
            prev_stall = ex_if.resp_valid && !ex_if.resp_ready;
            snap_id = ex_if.resp_id; snap_vd = ex_if.resp_vd; snap_rd = ex_if.resp_rd;
            if (ex_if.resp_valid && ex_if.resp_ready) begin
                checks++;
                if ({ex_if.resp_id, ex_if.resp_vd, ex_if.resp_rd} !==
                    {IdT'(8'h50 + got), {96'd0, exp_vd[got]}, 32'(exp_rd[got])}) begin
                    errors++;
                    $display("FAIL b2b_retire%0d got id %h vd %h rd %0d exp id %h vd %h rd %0d", got,
                             ex_if.resp_id, ex_if.resp_vd, ex_if.resp_rd, 8'h50 + got, exp_vd[got], exp_rd[got]);
                end
                got++;
            end
            if (ex_if.req_valid && !ex_if.req_ready && drop_at < 0) drop_at = sent;
            if (ex_if.req_valid && ex_if.req_ready) sent++;
            @(posedge clk);
            #1;
        end
        ex_if.req_valid = 1'b0;
        checks++;
        if (drop_at !== 2) begin errors++; $display("FAIL b2b_ready_drop got accepts %0d exp 2", drop_at); end
        checks++;
        if (got !== 5) begin errors++; $display("FAIL b2b_retired got %0d exp 5", got); end
    endtask

    task automatic test_streaming();
        int accepts;
        accepts = 0;
        ex_if.resp_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            if (c < 16) drive_req(IdT'(8'h60 + c), pack4(c, -c, 8 * c, -8 * c), 32'd0, 8'd4);
            else ex_if.req_valid = 1'b0;
            @(negedge clk);
            if (c < 16 && ex_if.req_ready) accepts++;
            if (c >= 2 && c < 18) begin
                checks++;
                if ({ex_if.resp_valid, ex_if.resp_id, ex_if.resp_vd, ex_if.resp_rd} !==
                    {1'b1, IdT'(8'h60 + c - 2),
                     {96'd0, 8'(-8 * (c - 2)), 8'(8 * (c - 2)), 8'(-(c - 2)), 8'(c - 2)}, 32'd0}) begin
                    errors++;
                    $display("FAIL stream_resp%0d got valid %b id %h vd %h rd %0d", c - 2,
                             ex_if.resp_valid, ex_if.resp_id, ex_if.resp_vd, ex_if.resp_rd);
                end
            end else begin
                checks++;
                if (ex_if.resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_idle_cycle%0d got valid %b exp 0", c, ex_if.resp_valid);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (accepts !== 16) begin errors++; $display("FAIL stream_accepts got %0d exp 16", accepts); end
    endtask

    task automatic test_reset_inflight();
        ex_if.resp_ready = 1'b0;
        drive_req(8'h71, pack4(300, 0, 0, 0), 32'd0, 8'd4);
        @(posedge clk); #1;
        drive_req(8'h72, pack4(1, 1, 1, 1), 32'd0, 8'd4);
        @(posedge clk); #1;
        ex_if.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({ex_if.resp_valid, ex_if.req_ready, ex_if.resp_rd} !== {1'b1, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL inflight_pre got valid %b ready %b rd %0d exp 1 0 1",
                     ex_if.resp_valid, ex_if.req_ready, ex_if.resp_rd);
        end
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({ex_if.resp_valid, ex_if.resp_id, ex_if.resp_vd, ex_if.resp_rd} !== '0) begin
            errors++;
            $display("FAIL inflight_async_clear got valid %b id %h vd %h rd %0d exp all 0",
                     ex_if.resp_valid, ex_if.resp_id, ex_if.resp_vd, ex_if.resp_rd);
        end
        checks++;
        if (ex_if.req_ready !== 1'b1) begin errors++; $display("FAIL inflight_ready_in_reset got %b exp 1", ex_if.req_ready); end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        ex_if.resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({ex_if.resp_valid, ex_if.req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL inflight_after_release%0d got valid %b ready %b exp 0 1",
                         c, ex_if.resp_valid, ex_if.req_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_relu();
        test_imm();
        test_extremes();
        test_back_to_back();
        test_streaming();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
